// File: rtl/audio_out_pkg.sv
// Shared types and constants for the PCM output path (stereo and multichannel).
package audio_out_pkg;

    // Modulation scheme applied to every channel for the current sample.
    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_DSM = 1'b1
    } mode_e;

    // Defaults shared with the stereo output stage.
    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 2;

    // Ceiling log2, used to size FIFO pointers, counts and the repeat counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock show-ahead FIFO holding whole PCM frames.
module audio_sample_fifo
    import audio_out_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEFAULT_CHANNELS * DEFAULT_WIDTH
) (
    input  logic                   clk_audio,
    input  logic                   aclr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int                PTR_W   = clog2(DEPTH);
    localparam logic [PTR_W:0]    DEPTH_C = DEPTH[PTR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Frame storage; DEPTH is a power of two so pointers wrap naturally.
    // NOTE: the storage array has no reset; only pointers and count need one, and
    // leaving it out keeps it mappable to plain RAM/register-file cells.
    always_ff @(posedge clk_audio) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_audio or negedge aclr) begin
        if (!aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_multichan_out.sv
// N-channel PCM output stage: frame FIFO, shared sample timebase and
// per-channel PWM / first-order delta-sigma modulators.
module audio_multichan_out
    import audio_out_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = 4,
    parameter int REPEAT   = 1
) (
    input  logic                      clk_audio,
    input  logic                      aclr,
    input  logic                      pcm_rdy,
    input  logic [CHANNELS*WIDTH-1:0] pcm,
    input  logic                      mode,
    output logic [CHANNELS-1:0]       out,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic                      overflow,
    output logic                      underrun
);

    localparam int                 FRAME_W  = CHANNELS * WIDTH;
    localparam int                 CNT_W    = clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C  = DEPTH[CNT_W-1:0];
    localparam int                 REP_W    = (REPEAT > 1) ? clog2(REPEAT) : 1;
    localparam logic [REP_W-1:0]   REP_LAST = REP_W'(REPEAT - 1);

    logic [WIDTH-1:0]   cnt;
    logic [REP_W-1:0]   rep;
    logic               boundary;
    logic               mode_change;
    logic               push_drop;
    logic [FRAME_W-1:0] fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic [FRAME_W-1:0] sample_q;
    mode_e              mode_q;

    assign boundary    = (&cnt) && (rep == REP_LAST);
    assign mode_change = boundary && (mode_e'(mode) != mode_q);
    // A frame arriving while full survives only if the boundary pops one out.
    assign push_drop   = pcm_rdy && (fifo_count == DEPTH_C) && !boundary;

    audio_sample_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (FRAME_W)
    ) u_fifo (
        .clk_audio (clk_audio),
        .aclr      (aclr),
        .push      (pcm_rdy),
        .pop       (boundary),
        .din       (pcm),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Phase counter spans one PWM period; repeat counter stretches a sample over REPEAT periods.
    always_ff @(posedge clk_audio or negedge aclr) begin
        if (!aclr) begin
            cnt <= '0;
            rep <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (&cnt) rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
        end
    end

    // Sample boundary: take the next frame (or hold on underrun), latch mode, track sticky flags.
    always_ff @(posedge clk_audio or negedge aclr) begin
        if (!aclr) begin
            sample_q <= '0;
            mode_q   <= MODE_PWM;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (boundary) begin
                mode_q <= mode_e'(mode);
                if (!fifo_empty) sample_q <= fifo_dout;
            end
            if (push_drop)               overflow <= 1'b1;
            if (boundary && fifo_empty)  underrun <= 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0] smp;
        logic [WIDTH-1:0] acc;
        logic [WIDTH:0]   sum;
        logic             out_q;

        // Channel 0 occupies the most significant slice of the frame.
        assign smp    = sample_q[(CHANNELS-1-c)*WIDTH +: WIDTH];
        // Only the low WIDTH bits of the accumulator feed back, so the carry is not stored.
        assign sum    = {1'b0, acc} + {1'b0, smp};
        assign out[c] = out_q;

        // Modulator: PWM compare against the phase, or delta-sigma carry; cleared on a mode switch.
        always_ff @(posedge clk_audio or negedge aclr) begin
            if (!aclr) begin
                acc   <= '0;
                out_q <= 1'b0;
            end else begin
                acc   <= mode_change ? '0 : sum[WIDTH-1:0];
                out_q <= (mode_q == MODE_PWM) ? (cnt < smp) : sum[WIDTH];
            end
        end
    end

endmodule
